// File: rtl/dnn_pkg.sv
// Shared definitions for the time-multiplexed fully-connected layer:
// FSM encodings, width derivation and the ReLU/saturation helper.
package dnn_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // At least one guard bit, so a single-term layer still cannot overflow
    function automatic int unsigned acc_width(input int unsigned in_w,
                                              input int unsigned w_w,
                                              input int unsigned n);
        return in_w + w_w + ((clog2(n) > 0) ? clog2(n) : 1);
    endfunction

    function automatic logic signed [63:0] relu_sat(input logic signed [63:0] v,
                                                    input int unsigned      out_w,
                                                    input logic             relu);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r  = (relu && (v < 0)) ? '0 : v;
        if (r > hi)      r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/dnn_mac_lane.sv
// One output neuron: signed multiply-accumulate over serial input terms,
// with ReLU + saturation applied when the final term is folded in.
module dnn_mac_lane
    import dnn_pkg::*;
#(
    parameter int IN_SIZE  = 7,
    parameter int W_SIZE   = 5,
    parameter int OUT_SIZE = 17,
    parameter int ACC_W    = 14,
    parameter int RELU     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                en,
    input  logic                load,
    input  logic [IN_SIZE-1:0]  x,
    input  logic [W_SIZE-1:0]   w,
    output logic [OUT_SIZE-1:0] y
);

    logic signed [IN_SIZE+W_SIZE-1:0] prod;
    logic signed [ACC_W-1:0]          acc;
    logic signed [ACC_W-1:0]          acc_next;

    assign prod     = $signed(x) * $signed(w);
    assign acc_next = acc + ACC_W'(prod);

    // The output is taken from acc_next so the last term lands in the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            y   <= '0;
        end else begin
            if (clear)   acc <= '0;
            else if (en) acc <= acc_next;
            if (load)    y   <= OUT_SIZE'(relu_sat(64'(acc_next), OUT_SIZE, RELU != 0));
        end
    end

endmodule

// File: rtl/dnn_layer_seq.sv
// Time-multiplexed fully-connected layer: one input term per cycle across
// all output lanes, valid/ready on both sides with output backpressure.
module dnn_layer_seq
    import dnn_pkg::*;
#(
    parameter int N_IN     = 4,
    parameter int N_OUT    = 4,
    parameter int IN_SIZE  = 7,
    parameter int W_SIZE   = 5,
    parameter int OUT_SIZE = 17,
    parameter int RELU     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_IN*IN_SIZE-1:0]        x_flat,
    input  logic [N_IN*N_OUT*W_SIZE-1:0]   w_flat,
    output logic [N_OUT*OUT_SIZE-1:0]      out_flat,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int ACC_W = int'(acc_width(IN_SIZE, W_SIZE, N_IN));
    localparam int KW    = (clog2(N_IN) > 0) ? int'(clog2(N_IN)) : 1;

    logic [1:0]                      state;
    logic [KW-1:0]                   k;
    logic [N_IN*IN_SIZE-1:0]         x_r;
    logic [N_IN*N_OUT*W_SIZE-1:0]    w_r;
    logic                            accept;
    logic                            last;

    assign in_ready = !rst && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready;
    assign last     = (state == S_ACC) && (k == KW'(N_IN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            k         <= '0;
            x_r       <= '0;
            w_r       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) state <= S_ACC;
                end
                S_ACC: begin
                    k <= k + 1'b1;
                    if (last) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        k         <= '0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= in_valid ? S_ACC : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (accept) begin
                x_r <= x_flat;
                w_r <= w_flat;
                k   <= '0;
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        dnn_mac_lane #(
            .IN_SIZE (IN_SIZE),
            .W_SIZE  (W_SIZE),
            .OUT_SIZE(OUT_SIZE),
            .ACC_W   (ACC_W),
            .RELU    (RELU)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .clear(accept),
            .en   (state == S_ACC),
            .load (last),
            .x    (x_r[k*IN_SIZE +: IN_SIZE]),
            .w    (w_r[(k*N_OUT+j)*W_SIZE +: W_SIZE]),
            .y    (out_flat[j*OUT_SIZE +: OUT_SIZE])
        );
    end

endmodule

// File: tb/tb_dnn_layer_seq.sv
// Directed bench: three layer instances (default, OUT_SIZE=12, RELU=1) share one stimulus stream.
module tb_dnn_layer_seq;

    localparam int N_IN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [27:0] x_flat;
    logic [79:0] w_flat;

    logic        rdy_def, vld_def, rdy_sat, vld_sat, rdy_relu, vld_relu;
    logic [67:0] out_def;
    logic [47:0] out_sat;
    logic [67:0] out_relu;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dnn_layer_seq u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_def),
        .x_flat(x_flat), .w_flat(w_flat), .out_flat(out_def),
        .out_valid(vld_def), .out_ready(out_ready)
    );

    dnn_layer_seq #(.OUT_SIZE(12)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_sat),
        .x_flat(x_flat), .w_flat(w_flat), .out_flat(out_sat),
        .out_valid(vld_sat), .out_ready(out_ready)
    );

    dnn_layer_seq #(.RELU(1)) u_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_relu),
        .x_flat(x_flat), .w_flat(w_flat), .out_flat(out_relu),
        .out_valid(vld_relu), .out_ready(out_ready)
    );

    function automatic logic signed [63:0] lane_def(input int j);
        return 64'($signed(out_def[j*17 +: 17]));
    endfunction

    function automatic logic signed [63:0] lane_sat(input int j);
        return 64'($signed(out_sat[j*12 +: 12]));
    endfunction

    function automatic logic signed [63:0] lane_relu(input int j);
        return 64'($signed(out_relu[j*17 +: 17]));
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_def4(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, "_def0"}, lane_def(0), 64'(e0));
        chk({tag, "_def1"}, lane_def(1), 64'(e1));
        chk({tag, "_def2"}, lane_def(2), 64'(e2));
        chk({tag, "_def3"}, lane_def(3), 64'(e3));
    endtask

    task automatic set_x4(input int a, input int b, input int c, input int d);
        x_flat = {7'(d), 7'(c), 7'(b), 7'(a)};
    endtask

    task automatic set_w(input int k, input int j, input int v);
        w_flat[(k*4+j)*5 +: 5] = 5'(v);
    endtask

    task automatic set_w_all(input int v);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                set_w(k, j, v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept from IDLE and run to the DONE cycle, checking latency on the way
    task automatic run_txn(input string tag);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, rdy_def, 0);
        for (int i = 0; i < N_IN - 1; i++) begin
            tick();
            chk({tag, "_early_vld"}, vld_def, 0);
        end
        tick();
        chk({tag, "_vld"}, vld_def, 1);
    endtask

    task automatic finish_txn(input string tag);
        tick();
        chk({tag, "_vld_drop"}, vld_def, 0);
        chk({tag, "_idle_rdy"}, rdy_def, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_flat    = '0;
        w_flat    = '0;
        tick();
        tick();
        chk("rst_vld", vld_def, 0);
        chk("rst_out", 64'(out_def), 0);
        chk("rst_rdy", rdy_def, 0);
        chk("rst_rdy_relu", rdy_relu, 0);
        chk("rst_out_sat", 64'(out_sat), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", rdy_def, 1);

        // Basic dot product
        set_x4(1, 2, 3, 4);
        set_w_all(1);
        run_txn("basic");
        chk_def4("basic", 10, 10, 10, 10);
        finish_txn("basic");
        chk("basic_hold", lane_def(2), 64'(10));

        // Saturation on the 12-bit instance
        set_x4(-64, -64, -64, -64);
        set_w_all(-16);
        run_txn("satpos");
        for (int j = 0; j < 4; j++) chk("satpos_sat", lane_sat(j), 64'(2047));
        chk_def4("satpos", 4096, 4096, 4096, 4096);
        finish_txn("satpos");
        set_w_all(15);
        run_txn("satneg");
        for (int j = 0; j < 4; j++) chk("satneg_sat", lane_sat(j), -64'sd2048);
        chk_def4("satneg", -3840, -3840, -3840, -3840);
        finish_txn("satneg");

        // ReLU against the linear instance
        set_x4(1, 1, 1, 1);
        for (int k = 0; k < 4; k++) begin
            set_w(k, 0, -3);
            set_w(k, 1, 2);
            set_w(k, 2, 0);
            set_w(k, 3, -1);
        end
        run_txn("relu");
        chk("relu_0", lane_relu(0), 64'(0));
        chk("relu_1", lane_relu(1), 64'(8));
        chk("relu_2", lane_relu(2), 64'(0));
        chk("relu_3", lane_relu(3), 64'(0));
        chk_def4("lin", -12, 8, 0, -4);
        finish_txn("relu");

        // Backpressure: held in_valid must not be taken while out_ready is low
        set_x4(1, 2, 3, 4);
        set_w_all(2);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        set_x4(1, 1, 1, 1);
        set_w_all(1);
        for (int i = 0; i < N_IN - 1; i++) begin
            tick();
            chk("bp_early_vld", vld_def, 0);
        end
        tick();
        chk("bp_vld", vld_def, 1);
        chk_def4("bp", 20, 20, 20, 20);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_vld", vld_def, 1);
            chk("bp_hold_out0", lane_def(0), 64'(20));
            chk("bp_hold_out3", lane_def(3), 64'(20));
            chk("bp_hold_rdy", rdy_def, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_comb", rdy_def, 1);
        tick();
        chk("bp_accept_vld", vld_def, 0);
        chk("bp_accept_busy", rdy_def, 0);
        chk("bp_out_held", lane_def(1), 64'(20));
        in_valid = 1'b0;
        for (int i = 0; i < N_IN - 1; i++) tick();
        tick();
        chk("bp2_vld", vld_def, 1);
        chk_def4("bp2", 4, 4, 4, 4);
        finish_txn("bp2");

        // Back-to-back: accepts 5 edges apart, each overlapping a DONE cycle
        set_x4(1, 2, 3, 4);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) set_w(k, j, j + 1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        set_x4(-1, -2, -3, -4);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) set_w(k, j, k - j);
        for (int i = 0; i < N_IN - 1; i++) tick();
        tick();
        chk("b2b_a_vld", vld_def, 1);
        chk("b2b_a_rdy", rdy_def, 1);
        chk_def4("b2b_a", 10, 20, 30, 40);
        tick();
        chk("b2b_b_acc_vld", vld_def, 0);
        chk("b2b_b_acc_rdy", rdy_def, 0);
        set_x4(63, -64, 10, 0);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) set_w(k, j, (k == j) ? 15 : -16);
        for (int i = 0; i < N_IN - 1; i++) tick();
        tick();
        chk("b2b_b_vld", vld_def, 1);
        chk_def4("b2b_b", -20, -10, 0, 10);
        tick();
        chk("b2b_c_acc_vld", vld_def, 0);
        chk("b2b_c_acc_rdy", rdy_def, 0);
        in_valid = 1'b0;
        for (int i = 0; i < N_IN - 1; i++) tick();
        tick();
        chk("b2b_c_vld", vld_def, 1);
        chk_def4("b2b_c", 1809, -2128, 166, -144);
        finish_txn("b2b_c");

        // Reset during the second ACC cycle abandons the transaction
        set_x4(5, 5, 5, 5);
        set_w_all(1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_vld", vld_def, 0);
        chk("midrst_out", 64'(out_def), 0);
        for (int i = 0; i < 5; i++) tick();
        chk("midrst_vld_later", vld_def, 0);
        chk("midrst_out_later", 64'(out_def), 0);
        chk("midrst_rdy", rdy_def, 1);
        set_x4(2, 2, 2, 2);
        set_w_all(1);
        run_txn("after_rst");
        chk_def4("after_rst", 8, 8, 8, 8);
        finish_txn("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
